washer_plant_model: RTL and testbench
=====================================

# washer_plant_model

Cycle-accurate responder model of the washing-machine hardware: water tank, detergent dispenser, wash-cycle timer and spin timer. It consumes the actuator commands driven by the washing-machine controller and returns the sensor handshakes that controller waits on: `filled`, `drained`, `detergent`, `cycletime_out` and `spintime_out`. It closes the loop in the day's testbench and can serve as a synthesizable plant for FPGA demo builds.

## Interface
- LEVEL_W, 8, water-level counter width
- FULL_LEVEL, 200, tank level that asserts `filled`; must be less than 2^LEVEL_W
- FILL_RATE, 4, level increment per tick while filling
- DRAIN_RATE, 8, level decrement per tick while draining
- DET_TICKS, 3, dispenser delay in ticks
- CYCLE_TICKS, 16, wash/rinse duration in ticks
- SPIN_TICKS, 10, spin duration in ticks
- TMR_W, 8, timer width; must hold the maximum of DET_TICKS, CYCLE_TICKS and SPIN_TICKS
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick_en  in  1  one-cycle time-base strobe; the plant evolves only on cycles where it is 1
- doorlock, fillvalve_on, drainvalve_on, motor_on, soap_wash, water_wash, done  in  1 each  controller commands
- filled, drained, detergent, cycletime_out, spintime_out  out  1 each  sensor handshakes, all registered
- water_level  out  LEVEL_W  current tank level
- fault  out  1  sticky plant-misuse flag

## Operation
- Tank, evaluated on each tick:
  - fill only: level = min(level+FILL_RATE, FULL_LEVEL)
  - drain only: level = max(level−DRAIN_RATE, 0); no underflow wrap
  - both valves on: level holds
  - `filled` = (level==FULL_LEVEL); `drained` = (level==0)
- Dispenser FSM, states DET_IDLE, DET_DISP, DET_DONE:
  - DET_IDLE → DET_DISP on a rising edge of `soap_wash` (previous value registered); the delay counter clears.
  - DET_DISP counts ticks; after DET_TICKS ticks it moves to DET_DONE.
  - DET_DONE drives `detergent`=1 and holds it while `soap_wash`=1; when `soap_wash`=0 it returns to DET_IDLE.
- Cycle timer:
  - increments on each tick while `motor_on`=1, saturating at CYCLE_TICKS
  - `cycletime_out` = (count==CYCLE_TICKS) and stays held
  - clears when `fillvalve_on`=1, so the rinse pass starts from 0
- Spin timer:
  - increments on each tick while `drainvalve_on`=1 and `water_wash`=1 and level==0, saturating at SPIN_TICKS
  - `spintime_out` = (count==SPIN_TICKS)
  - clears on `done`=1
- `doorlock`=0 clears both timers and returns the dispenser to DET_IDLE. Water level is unaffected, since the water physically remains in the tank.
- Faults (sticky until reset):
  - both valves on during a tick
  - `motor_on`=1 while `doorlock`=0
  - `motor_on`=1 while level==0 on a tick (dry run)

## Timing
- All outputs are registered. An output change is visible on the clk edge after the tick cycle that caused it (1-cycle latency).
- Reset values:
  - water_level=0
  - drained=1 (derived from level 0)
  - filled, detergent, cycletime_out, spintime_out, fault = 0
  - dispenser in DET_IDLE, timers at 0
- Cycles with tick_en=0 change no level or timer state. Rising-edge detection of `soap_wash` and the door/done/fill clears still act every clk.
- Priority within one cycle: door clear > done/fill clear > count increment. A `soap_wash` rise in the same cycle as `doorlock`=0 is ignored.
- Reset asserted mid-fill returns to the reset values immediately (asynchronous); the level is lost.

## Configuration
- WASHER_PLANT_FAULT_EN:
  - defined: fault detection logic and the sticky `fault` register are built
  - undefined: `fault` is tied to 0, no detection logic exists, and a both-valves-on tick still holds the level

## Structure
- Package `washer_pkg`:
  - dispenser state enum (DET_IDLE/DET_DISP/DET_DONE)
  - default rate, threshold and tick constants
  - shared with the controller bench
- Sub-module `washer_tick_timer`: saturating tick counter with synchronous clear, enable, terminal value and a `expired` flag. Instantiated for the dispenser delay, the cycle timer and the spin timer.

## Test plan
- Reset, then fillvalve_on=1 with tick every cycle:
  - `filled`=1 on the clock edge ending the 50th tick cycle; water_level=200
  - drained=0 after the first tick
- From level 200, drainvalve_on=1:
  - level goes 192, 184, …; drained=1 after 25 ticks
  - further ticks keep level at 0
- soap_wash rises: detergent=1 one cycle after the 3rd tick; soap_wash falls → detergent=0 next cycle.
- motor_on for 20 ticks: cycletime_out=1 after tick 16 and stays held; a fillvalve_on pulse clears it.
- fillvalve_on and drainvalve_on both 1 for one tick (macro defined): level unchanged, fault=1 and stays 1 until rst=0.
- Spin at level 0 with water_wash=1 and drainvalve_on=1: spintime_out=1 after 10 ticks. doorlock dropped at tick 5 instead: the count restarts from 0.

Source files
------------

// File: rtl/washer_pkg.sv
// washer_pkg: shared types and default constants for the washing-machine
// plant model and the controller bench.
//   det_state_t  - dispenser FSM states (DET_IDLE / DET_DISP / DET_DONE)
//   DEF_*        - default widths, rates, thresholds and tick counts
//   sat_inc      - saturating increment helper
package washer_pkg;

    typedef enum logic [1:0] {
        DET_IDLE = 2'd0,
        DET_DISP = 2'd1,
        DET_DONE = 2'd2
    } det_state_t;

    localparam int DEF_LEVEL_W     = 8;
    localparam int DEF_FULL_LEVEL  = 200;
    localparam int DEF_FILL_RATE   = 4;
    localparam int DEF_DRAIN_RATE  = 8;
    localparam int DEF_DET_TICKS   = 3;
    localparam int DEF_CYCLE_TICKS = 16;
    localparam int DEF_SPIN_TICKS  = 10;
    localparam int DEF_TMR_W       = 8;

    // Increment by one unless already at the terminal value.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] term);
        if (value >= term) begin
            sat_inc = term;
        end else begin
            sat_inc = value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/washer_tick_timer.sv
// washer_tick_timer: saturating tick counter.
//   clk, rst     - clock, asynchronous active-low reset
//   clr          - synchronous clear (wins over en)
//   en           - count one step this cycle
//   expired      - registered flag, high while the count sits at TERM
module washer_tick_timer
    import washer_pkg::*;
#(
    parameter int W    = 8,
    parameter int TERM = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;
    logic         expired_r;

    // Next count: clear first, then saturating increment.
    always_comb begin
        count_next_s = count_r;
        if (clr) begin
            count_next_s = {W{1'b0}};
        end else if (en) begin
            count_next_s = W'(sat_inc(32'(count_r), 32'(TERM_V)));
        end else begin
            count_next_s = count_r;
        end
    end

    // Count and terminal flag registers; the flag tracks the new count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r   <= {W{1'b0}};
            expired_r <= 1'b0;
        end else begin
            count_r   <= count_next_s;
            expired_r <= (count_next_s == TERM_V);
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/washer_plant_model.sv
// washer_plant_model: cycle-accurate responder for the washer controller.
// Models tank level, detergent dispenser, wash-cycle timer and spin timer.
//   clk, rst         - clock, asynchronous active-low reset
//   tick_en          - time-base strobe; level/timers evolve only on ticks
//   doorlock .. done - controller actuator commands
//   filled, drained, detergent, cycletime_out, spintime_out - registered
//                      sensor handshakes
//   water_level      - current tank level
//   fault            - sticky misuse flag
// Build option: define WASHER_PLANT_FAULT_EN to build the misuse detector;
// otherwise fault is tied low.
module washer_plant_model
    import washer_pkg::*;
#(
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int FULL_LEVEL  = DEF_FULL_LEVEL,
    parameter int FILL_RATE   = DEF_FILL_RATE,
    parameter int DRAIN_RATE  = DEF_DRAIN_RATE,
    parameter int DET_TICKS   = DEF_DET_TICKS,
    parameter int CYCLE_TICKS = DEF_CYCLE_TICKS,
    parameter int SPIN_TICKS  = DEF_SPIN_TICKS,
    parameter int TMR_W       = DEF_TMR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_en,
    input  logic               doorlock,
    input  logic               fillvalve_on,
    input  logic               drainvalve_on,
    input  logic               motor_on,
    input  logic               soap_wash,
    input  logic               water_wash,
    input  logic               done,
    output logic               filled,
    output logic               drained,
    output logic               detergent,
    output logic               cycletime_out,
    output logic               spintime_out,
    output logic [LEVEL_W-1:0] water_level,
    output logic               fault
);

    localparam logic [LEVEL_W:0]   FULL_X  = (LEVEL_W+1)'(FULL_LEVEL);
    localparam logic [LEVEL_W:0]   FILL_X  = (LEVEL_W+1)'(FILL_RATE);
    localparam logic [LEVEL_W-1:0] FULL_V  = LEVEL_W'(FULL_LEVEL);
    localparam logic [LEVEL_W-1:0] DRAIN_V = LEVEL_W'(DRAIN_RATE);
    localparam logic [LEVEL_W-1:0] ZERO_V  = {LEVEL_W{1'b0}};

    logic [LEVEL_W-1:0] level_r;
    logic [LEVEL_W-1:0] level_next_s;
    logic [LEVEL_W:0]   level_up_s;
    logic               filled_r;
    logic               drained_r;
    det_state_t         det_state_r;
    logic               detergent_r;
    logic               soap_prev_r;
    logic               soap_rise_s;
    logic               det_expired_s;
    logic               cyc_expired_s;
    logic               spin_expired_s;
    logic               level_empty_s;

    assign level_up_s    = {1'b0, level_r} + FILL_X;
    assign soap_rise_s   = soap_wash & ~soap_prev_r;
    assign level_empty_s = (level_r == ZERO_V);

    // Tank level for this cycle; both valves open holds the level.
    always_comb begin
        level_next_s = level_r;
        if (tick_en && fillvalve_on && !drainvalve_on) begin
            level_next_s = (level_up_s >= FULL_X) ? FULL_V : level_up_s[LEVEL_W-1:0];
        end else if (tick_en && drainvalve_on && !fillvalve_on) begin
            level_next_s = (level_r < DRAIN_V) ? ZERO_V : (level_r - DRAIN_V);
        end else begin
            level_next_s = level_r;
        end
    end

    // Tank level and level sensors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r   <= ZERO_V;
            filled_r  <= 1'b0;
            drained_r <= 1'b1;
        end else begin
            level_r   <= level_next_s;
            filled_r  <= (level_next_s == FULL_V);
            drained_r <= (level_next_s == ZERO_V);
        end
    end

    // The dispenser leaves DET_DISP on the tick that would bring the delay
    // count to DET_TICKS, so the timer terminal is one short of that and
    // detergent lands on the edge ending the last dispensing tick.
    washer_tick_timer #(.W(TMR_W), .TERM(DET_TICKS - 1)) u_det_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (~doorlock | (det_state_r == DET_IDLE)),
        .en      (tick_en & (det_state_r == DET_DISP)),
        .expired (det_expired_s)
    );

    washer_tick_timer #(.W(TMR_W), .TERM(CYCLE_TICKS)) u_cycle_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (~doorlock | fillvalve_on),
        .en      (tick_en & motor_on),
        .expired (cyc_expired_s)
    );

    washer_tick_timer #(.W(TMR_W), .TERM(SPIN_TICKS)) u_spin_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (~doorlock | done),
        .en      (tick_en & drainvalve_on & water_wash & level_empty_s),
        .expired (spin_expired_s)
    );

    // Dispenser FSM; an open door aborts it and masks any soap_wash rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_state_r <= DET_IDLE;
            detergent_r <= 1'b0;
            soap_prev_r <= 1'b0;
        end else begin
            soap_prev_r <= soap_wash;
            if (!doorlock) begin
                det_state_r <= DET_IDLE;
                detergent_r <= 1'b0;
            end else begin
                case (det_state_r)
                    DET_IDLE: begin
                        detergent_r <= 1'b0;
                        if (soap_rise_s) begin
                            det_state_r <= DET_DISP;
                        end else begin
                            det_state_r <= DET_IDLE;
                        end
                    end
                    DET_DISP: begin
                        if (tick_en && det_expired_s) begin
                            det_state_r <= DET_DONE;
                            detergent_r <= 1'b1;
                        end else begin
                            det_state_r <= DET_DISP;
                            detergent_r <= 1'b0;
                        end
                    end
                    DET_DONE: begin
                        if (!soap_wash) begin
                            det_state_r <= DET_IDLE;
                            detergent_r <= 1'b0;
                        end else begin
                            det_state_r <= DET_DONE;
                            detergent_r <= 1'b1;
                        end
                    end
                    default: begin
                        det_state_r <= DET_IDLE;
                        detergent_r <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef WASHER_PLANT_FAULT_EN
    logic fault_r;
    logic misuse_s;

    assign misuse_s = (tick_en & fillvalve_on & drainvalve_on)
                    | (motor_on & ~doorlock)
                    | (tick_en & motor_on & level_empty_s);

    // Sticky misuse flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_r <= 1'b0;
        end else if (misuse_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

    assign filled        = filled_r;
    assign drained       = drained_r;
    assign water_level   = level_r;
    assign detergent     = detergent_r;
    assign cycletime_out = cyc_expired_s;
    assign spintime_out  = spin_expired_s;

endmodule

// File: tb/tb_washer_plant_model.sv
// tb_washer_plant_model: directed and randomized stimulus for
// washer_plant_model, checked every cycle against a behavioural model.
module tb_washer_plant_model;

    localparam int FULL  = 200;
    localparam int FILLR = 4;
    localparam int DRNR  = 8;
    localparam int DETT  = 3;
    localparam int CYCT  = 16;
    localparam int SPNT  = 10;
`ifdef WASHER_PLANT_FAULT_EN
    localparam int FAULT_ON = 1;
`else
    localparam int FAULT_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_en, doorlock, fillvalve_on, drainvalve_on, motor_on;
    logic       soap_wash, water_wash, done;
    logic       filled, drained, detergent, cycletime_out, spintime_out, fault;
    logic [7:0] water_level;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int m_level, m_cyc, m_spin, m_det_ticks;
    bit m_dispensing, m_det_out, m_prev_soap, m_fault;

    washer_plant_model dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .doorlock(doorlock),
        .fillvalve_on(fillvalve_on), .drainvalve_on(drainvalve_on),
        .motor_on(motor_on), .soap_wash(soap_wash), .water_wash(water_wash),
        .done(done), .filled(filled), .drained(drained), .detergent(detergent),
        .cycletime_out(cycletime_out), .spintime_out(spintime_out),
        .water_level(water_level), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_cyc = 0; m_spin = 0; m_det_ticks = 0;
        m_dispensing = 0; m_det_out = 0; m_prev_soap = 0; m_fault = 0;
    endtask

    // One clock of plant behaviour from the current inputs.
    task automatic model_step();
        int  old_level;
        bit  rise;
        old_level   = m_level;
        rise        = soap_wash && !m_prev_soap;
        m_prev_soap = soap_wash;
        if (tick_en && fillvalve_on && !drainvalve_on)
            m_level = (m_level + FILLR > FULL) ? FULL : m_level + FILLR;
        else if (tick_en && drainvalve_on && !fillvalve_on)
            m_level = (m_level < DRNR) ? 0 : m_level - DRNR;
        if (!doorlock || fillvalve_on) m_cyc = 0;
        else if (tick_en && motor_on && m_cyc < CYCT) m_cyc++;
        if (!doorlock || done) m_spin = 0;
        else if (tick_en && drainvalve_on && water_wash && old_level == 0 && m_spin < SPNT) m_spin++;
        if (!doorlock) begin
            m_dispensing = 0; m_det_out = 0;
        end else if (m_det_out) begin
            if (!soap_wash) m_det_out = 0;
        end else if (m_dispensing) begin
            if (tick_en) m_det_ticks++;
            if (m_det_ticks == DETT) begin m_det_out = 1; m_dispensing = 0; end
        end else if (rise) begin
            m_dispensing = 1; m_det_ticks = 0;
        end
        if (FAULT_ON != 0) begin
            if ((tick_en && fillvalve_on && drainvalve_on) || (motor_on && !doorlock) ||
                (tick_en && motor_on && old_level == 0)) m_fault = 1;
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".level"},     32'(water_level),   32'(m_level));
        check({ph, ".filled"},    32'(filled),        32'(m_level == FULL));
        check({ph, ".drained"},   32'(drained),       32'(m_level == 0));
        check({ph, ".detergent"}, 32'(detergent),     32'(m_det_out));
        check({ph, ".cycle"},     32'(cycletime_out), 32'(m_cyc == CYCT));
        check({ph, ".spin"},      32'(spintime_out),  32'(m_spin == SPNT));
        check({ph, ".fault"},     32'(fault),         32'(m_fault));
    endtask

    task automatic set_in(input bit fl, input bit dr, input bit mo, input bit so,
                          input bit ww, input bit dn, input bit dl, input bit tk);
        fillvalve_on = fl; drainvalve_on = dr; motor_on = mo; soap_wash = so;
        water_wash = ww; done = dn; doorlock = dl; tick_en = tk;
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        #1;
        model_step();
        compare_all(ph);
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1'b1;

        // Fill from empty: filled on the 50th tick.
        set_in(1, 0, 0, 0, 0, 0, 1, 1);
        step("fill");
        check("drained_after_tick1", 32'(drained), 32'd0);
        repeat (48) step("fill");
        check("filled_tick49", 32'(filled), 32'd0);
        step("fill");
        check("filled_tick50", 32'(filled), 32'd1);
        check("level_tick50", 32'(water_level), 32'd200);

        // Drain: empty after 25 ticks, then stays at 0.
        set_in(0, 1, 0, 0, 0, 0, 1, 1);
        repeat (24) step("drain");
        check("drained_tick24", 32'(drained), 32'd0);
        step("drain");
        check("drained_tick25", 32'(drained), 32'd1);
        repeat (3) step("drain_floor");
        check("level_floor", 32'(water_level), 32'd0);

        // Dispenser.
        set_in(0, 0, 0, 1, 0, 0, 1, 1);
        step("soap_rise");
        repeat (2) step("soap");
        check("det_tick2", 32'(detergent), 32'd0);
        step("soap");
        check("det_tick3", 32'(detergent), 32'd1);
        step("soap_hold");
        set_in(0, 0, 0, 0, 0, 0, 1, 1);
        step("soap_fall");
        check("det_fall", 32'(detergent), 32'd0);

        // Refill then run motor for 20 ticks.
        set_in(1, 0, 0, 0, 0, 0, 1, 1);
        repeat (50) step("refill");
        set_in(0, 0, 1, 0, 0, 0, 1, 1);
        repeat (15) step("motor");
        check("cycle_tick15", 32'(cycletime_out), 32'd0);
        step("motor");
        check("cycle_tick16", 32'(cycletime_out), 32'd1);
        repeat (4) step("motor_hold");
        check("cycle_held", 32'(cycletime_out), 32'd1);
        set_in(1, 0, 1, 0, 0, 0, 1, 1);
        step("fill_pulse");
        check("cycle_cleared", 32'(cycletime_out), 32'd0);

        // Spin at level 0.
        set_in(0, 1, 0, 0, 0, 0, 1, 1);
        repeat (26) step("spin_drain");
        set_in(0, 1, 0, 0, 1, 0, 1, 1);
        repeat (9) step("spin");
        check("spin_tick9", 32'(spintime_out), 32'd0);
        step("spin");
        check("spin_tick10", 32'(spintime_out), 32'd1);
        set_in(0, 1, 0, 0, 1, 1, 1, 1);
        step("spin_done");
        check("spin_done_clear", 32'(spintime_out), 32'd0);
        set_in(0, 1, 0, 0, 1, 0, 1, 1);
        repeat (4) step("spin2");
        set_in(0, 1, 0, 0, 1, 0, 0, 1);
        step("spin_door");
        set_in(0, 1, 0, 0, 1, 0, 1, 1);
        repeat (9) step("spin3");
        check("spin_restart9", 32'(spintime_out), 32'd0);
        step("spin3");
        check("spin_restart10", 32'(spintime_out), 32'd1);

        // Both valves for one tick.
        set_in(1, 1, 0, 0, 0, 0, 1, 1);
        step("both_valves");
        check("both_level", 32'(water_level), 32'd0);
        check("both_fault", 32'(fault), 32'(FAULT_ON));
        set_in(0, 0, 0, 0, 0, 0, 1, 1);
        repeat (3) step("fault_sticky");
        check("fault_sticky", 32'(fault), 32'(FAULT_ON));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0, $urandom_range(1, 0) == 1,
                   $urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, $urandom_range(31, 0) == 0,
                   $urandom_range(15, 0) != 0, $urandom_range(3, 0) != 0);
            step("rand");
        end

        // Asynchronous reset mid-fill.
        set_in(1, 0, 0, 0, 0, 0, 1, 1);
        repeat (10) step("prefill");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_level", 32'(water_level), 32'd0);
        check("rst_drained", 32'(drained), 32'd1);
        check("rst_fault", 32'(fault), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) step("post_reset_fill");
        check("post_reset_level", 32'(water_level), 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
